// File: rtl/tx_mix.sv
// Quadrature upconverter for the TX path: forms I*cos - Q*sin from baseband I/Q and NCO
// carrier words, applies an unsigned gain (128 = unity) and saturates to the DAC width.
// One shared 18x18 multiplier handles both terms, so one sample is accepted every 2 clocks.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en                  transmit enable; low clears the datapath synchronously
//   iq_i, iq_q          signed 18-bit baseband sample
//   iq_valid, iq_ready  input handshake (ready = en & phase A)
//   cos, sin            signed 18-bit carrier words, captured with each accept slot
//   gain                unsigned 8-bit gain, 128 = unity
//   dac, dac_valid      signed IF sample and its one-cycle update strobe
//   underrun            one-cycle strobe, no sample offered at the accept slot
module tx_mix #(
  parameter int unsigned DAC_WIDTH = 14
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic signed [17:0]          iq_i,
  input  logic signed [17:0]          iq_q,
  input  logic                        iq_valid,
  output logic                        iq_ready,
  input  logic signed [17:0]          cos,
  input  logic signed [17:0]          sin,
  input  logic [7:0]                  gain,
  output logic signed [DAC_WIDTH-1:0] dac,
  output logic                        dac_valid,
  output logic                        underrun
);

  localparam int unsigned Sh = 25 - DAC_WIDTH;
  localparam logic signed [27:0] DacMax = 28'((1 << (DAC_WIDTH - 1)) - 1);
  localparam logic signed [27:0] DacMin = 28'(-(1 << (DAC_WIDTH - 1)));

  typedef enum logic {StA, StB} phase_e;

  phase_e state_q, state_d;

  logic signed [17:0]          i_q, q_q, cos_q, sin_q;
  logic signed [35:0]          prod_q, ic_q;
  logic signed [17:0]          s18_q;
  logic signed [26:0]          g_q;
  logic signed [DAC_WIDTH-1:0] dac_q;
  logic                        dac_valid_q, underrun_q;
  // Sample-slot tags; bit n is set n+1 edges after an accept slot.
  logic [4:0]                  tag_q;

  logic                        accept_slot;
  logic signed [17:0]          mul_a, mul_b;
  logic signed [35:0]          mul_p;
  logic signed [36:0]          sum;
  logic signed [19:0]          sum_rnd;
  logic signed [17:0]          s18_d;
  logic signed [26:0]          g_d;
  logic signed [27:0]          out_rnd;
  logic signed [DAC_WIDTH-1:0] dac_d;

  assign accept_slot = en && (state_q == StA);
  assign iq_ready    = accept_slot && !rst;

  always_comb begin
    state_d = StA;
    if (en) begin
      state_d = (state_q == StA) ? StB : StA;
    end
  end

  // Leaving B: I*cos. Leaving A: Q*sin from the registers captured in the previous slot.
  always_comb begin
    mul_a = (state_q == StB) ? i_q   : q_q;
    mul_b = (state_q == StB) ? cos_q : sin_q;
    mul_p = $signed({{18{mul_a[17]}}, mul_a}) * $signed({{18{mul_b[17]}}, mul_b});
  end

  always_comb begin
    sum     = $signed({ic_q[35], ic_q}) - $signed({prod_q[35], prod_q});
    sum_rnd = $signed(sum[36:17]) + $signed({19'd0, sum[16]});
    if (sum_rnd > 20'sd131071) begin
      s18_d = 18'sd131071;
    end else if (sum_rnd < -20'sd131072) begin
      s18_d = -18'sd131072;
    end else begin
      s18_d = sum_rnd[17:0];
    end
  end

  assign g_d = $signed({{9{s18_q[17]}}, s18_q}) * $signed({19'd0, gain});

  always_comb begin
    out_rnd = ($signed({g_q[26], g_q}) >>> Sh) + $signed({27'd0, g_q[Sh-1]});
    if (out_rnd > DacMax) begin
      dac_d = DacMax[DAC_WIDTH-1:0];
    end else if (out_rnd < DacMin) begin
      dac_d = DacMin[DAC_WIDTH-1:0];
    end else begin
      dac_d = out_rnd[DAC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      state_q     <= StA;
      i_q         <= '0;
      q_q         <= '0;
      cos_q       <= '0;
      sin_q       <= '0;
      prod_q      <= '0;
      ic_q        <= '0;
      s18_q       <= '0;
      g_q         <= '0;
      dac_q       <= '0;
      dac_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= {tag_q[3:0], accept_slot};
      underrun_q  <= accept_slot && !iq_valid;
      dac_valid_q <= tag_q[4];
      prod_q      <= mul_p;
      if (accept_slot) begin
        cos_q <= cos;
        sin_q <= sin;
        // A starved slot still runs the pipeline, with zero data.
        i_q   <= iq_valid ? iq_i : '0;
        q_q   <= iq_valid ? iq_q : '0;
        ic_q  <= prod_q;
      end
      if (tag_q[2]) s18_q <= s18_d;
      if (tag_q[3]) g_q   <= g_d;
      if (tag_q[4]) dac_q <= dac_d;
    end
  end

  assign dac       = dac_q;
  assign dac_valid = dac_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_tx_mix.sv
module tb_tx_mix;

  logic               clk = 1'b0;
  logic               rst, en, iq_valid;
  logic signed [17:0] iq_i, iq_q, cos_w, sin_w;
  logic [7:0]         gain;
  logic               iq_ready, dac_valid, underrun;
  logic signed [13:0] dac;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_mix #(.DAC_WIDTH(14)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .iq_i      (iq_i),
    .iq_q      (iq_q),
    .iq_valid  (iq_valid),
    .iq_ready  (iq_ready),
    .cos       (cos_w),
    .sin       (sin_w),
    .gain      (gain),
    .dac       (dac),
    .dac_valid (dac_valid),
    .underrun  (underrun)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Flush, then stream one held sample and check the first output strobe.
  task automatic run_one(input string tag, input int i, input int q, input int c, input int s,
                         input int g, input int exp);
    en = 1'b0;
    step();
    check({tag, "_flush_dac"}, dac, 0);
    iq_i = 18'(i); iq_q = 18'(q); cos_w = 18'(c); sin_w = 18'(s); gain = 8'(g);
    iq_valid = 1'b1;
    en = 1'b1;
    step();
    repeat (4) step();
    check({tag, "_early"}, dac_valid, 0);
    step();
    check({tag, "_valid"}, dac_valid, 1);
    check({tag, "_dac"}, dac, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int vals [4];
    int exps [4];
    int idx, outs;
    logic acc;
    vals = '{16384, -16384, 32768, 65536};
    exps = '{1024, -1024, 2048, 4096};

    rst = 1'b1; en = 1'b0; iq_valid = 1'b0;
    iq_i = '0; iq_q = '0; cos_w = '0; sin_w = '0; gain = 8'd128;
    repeat (3) step();
    check("rst_ready", iq_ready, 0);
    check("rst_dac", dac, 0);
    check("rst_dac_valid", dac_valid, 0);
    check("rst_underrun", underrun, 0);
    en = 1'b1;
    #1;
    check("rst_ready_en", iq_ready, 0);

    // Unity gain, I only; latency and strobe cadence.
    rst = 1'b0; iq_valid = 1'b1; iq_i = 18'sd65536; cos_w = 18'sd131071;
    #1;
    check("u_ready0", iq_ready, 1);
    step();
    check("u_ready1", iq_ready, 0);
    check("u_underrun", underrun, 0);
    repeat (4) step();
    check("u_early", dac_valid, 0);
    step();
    check("u_valid", dac_valid, 1);
    check("u_dac", dac, 4096);
    step();
    check("u_gap", dac_valid, 0);
    check("u_hold", dac, 4096);
    step();
    check("u_valid2", dac_valid, 1);

    run_one("qsign", 0, 65536, 0, 131071, 128, -4096);
    run_one("satpos", 131071, -131072, 131071, 131071, 255, 8191);
    run_one("satneg", -131071, 131071, 131071, 131071, 255, -8192);
    run_one("gainhalf", 65536, 0, 131071, 0, 64, 2048);

    // Underrun: starved slots still strobe with zero data.
    en = 1'b0;
    step();
    iq_valid = 1'b0; iq_i = 18'sd65536; cos_w = 18'sd131071; sin_w = '0; gain = 8'd128;
    en = 1'b1;
    #1;
    check("ur_ready0", iq_ready, 1);
    for (int j = 1; j <= 10; j++) begin
      step();
      check("ur_underrun", underrun, (j % 2 == 1) ? 1 : 0);
      check("ur_ready", iq_ready, (j % 2 == 0) ? 1 : 0);
      check("ur_valid", dac_valid, (j >= 6 && j % 2 == 0) ? 1 : 0);
      if (j >= 6 && j % 2 == 0) check("ur_dac", dac, 0);
    end

    // Handshake: four distinct samples, in order, none dropped or duplicated.
    en = 1'b0;
    step();
    idx = 0; outs = 0;
    iq_i = 18'(vals[0]); iq_q = 18'sd12345; iq_valid = 1'b1;
    en = 1'b1;
    #1;
    for (int c = 0; c < 13; c++) begin
      check("hs_ready", iq_ready, (c % 2 == 0) ? 1 : 0);
      acc = iq_ready & iq_valid;
      step();
      if (acc) begin
        idx++;
        if (idx < 4) iq_i = 18'(vals[idx]);
        else iq_valid = 1'b0;
      end
      if (dac_valid) begin
        if (outs < 4) check("hs_dac", dac, exps[outs]);
        outs++;
      end
    end
    check("hs_accepts", idx, 4);
    check("hs_strobes", outs, 4);

    // Flush by en: in-flight sample discarded, restart immediately.
    en = 1'b0;
    step();
    iq_i = 18'sd65536; iq_q = '0; cos_w = 18'sd131071; sin_w = '0; gain = 8'd128;
    iq_valid = 1'b1; en = 1'b1;
    step();
    repeat (5) step();
    check("fl_pre_valid", dac_valid, 1);
    check("fl_pre_dac", dac, 4096);
    repeat (4) step();
    en = 1'b0;
    #1;
    check("fl_ready_low", iq_ready, 0);
    step();
    check("fl_dac", dac, 0);
    check("fl_valid", dac_valid, 0);
    iq_i = 18'sd32768;
    en = 1'b1;
    #1;
    check("fl_ready", iq_ready, 1);
    step();
    for (int j = 0; j < 4; j++) begin
      step();
      check("fl_drop", dac_valid, 0);
    end
    step();
    check("fl_new_valid", dac_valid, 1);
    check("fl_new_dac", dac, 2048);

    // Flush by rst pulse mid-stream.
    step();
    rst = 1'b1;
    step();
    check("rp_dac", dac, 0);
    check("rp_valid", dac_valid, 0);
    check("rp_underrun", underrun, 0);
    rst = 1'b0;
    iq_i = -18'sd16384;
    #1;
    check("rp_ready", iq_ready, 1);
    step();
    repeat (4) step();
    check("rp_early", dac_valid, 0);
    step();
    check("rp_valid2", dac_valid, 1);
    check("rp_dac2", dac, -1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
